wb_repne_cmps_sequencer: RTL and testbench

// Sequences the two-uop CMPS pair and REPNE iteration at writeback, and latches HALT.

---
 rtl/wb_repne_cmps_sequencer.sv | 78 +++++++
 tb/tb_wb_repne_cmps_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_repne_cmps_sequencer.sv
// wb_repne_cmps_sequencer: writeback sequencing of the CMPS uop pair, REPNE replay/terminate and sticky HALT
module wb_repne_cmps_sequencer #(
  parameter int CNT_W  = 32,
  parameter int ITER_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_V,
  input  logic              CS_IS_CMPS_FIRST_UOP_ALL,
  input  logic              CS_IS_CMPS_SECOND_UOP_ALL,
  input  logic              WB_d2_repne_wb,
  input  logic              CS_IS_HALT_WB,
  input  logic [31:0]       current_flags,
  input  logic [CNT_W-1:0]  WB_RESULT_C,
  output logic              cmps_ptr_en,
  output logic              repne_pending,
  output logic              repne_replay,
  output logic              repne_terminate,
  output logic              cmps_done,
  output logic              wb_halt_all,
  output logic              protocol_error,
  output logic [ITER_W-1:0] iter_count
);
  typedef enum logic [1:0] {IDLE, FIRST, REPLAY, HALTED} state_t;
  state_t r_state;
  logic w_first, w_second, w_halt, w_term;
  assign w_first     = WB_V & CS_IS_CMPS_FIRST_UOP_ALL;
  assign w_second    = WB_V & CS_IS_CMPS_SECOND_UOP_ALL;
  assign w_halt      = WB_V & CS_IS_HALT_WB;
  assign w_term      = current_flags[6] | (WB_RESULT_C == '0);
  assign cmps_ptr_en = w_first & ~CS_IS_HALT_WB & (r_state != HALTED);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= IDLE;
      repne_pending   <= 1'b0;
      repne_replay    <= 1'b0;
      repne_terminate <= 1'b0;
      cmps_done       <= 1'b0;
      wb_halt_all     <= 1'b0;
      protocol_error  <= 1'b0;
      iter_count      <= '0;
    end else begin
      repne_replay    <= 1'b0;
      repne_terminate <= 1'b0;
      cmps_done       <= 1'b0;
      if (r_state != HALTED) begin
        if (w_halt) begin
          r_state     <= HALTED;
          wb_halt_all <= 1'b1;
        end else if (w_first) begin
          r_state       <= FIRST;
          repne_pending <= 1'b1;
          if (r_state == FIRST) protocol_error <= 1'b1;
        end else if (w_second) begin
          if (r_state != FIRST) begin
            r_state        <= IDLE;
            protocol_error <= 1'b1;
          end else if (!WB_d2_repne_wb) begin
            r_state       <= IDLE;
            cmps_done     <= 1'b1;
            repne_pending <= 1'b0;
          end else if (w_term) begin
            r_state         <= IDLE;
            repne_terminate <= 1'b1;
            repne_pending   <= 1'b0;
            iter_count      <= '0;
          end else begin
            r_state      <= REPLAY;
            repne_replay <= 1'b1;
            iter_count   <= (&iter_count) ? iter_count : iter_count + 1'b1;
          end
        end else if (r_state == REPLAY) begin
          r_state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_repne_cmps_sequencer.sv
// tb_wb_repne_cmps_sequencer: directed scenarios plus randomized traffic checked against an event-level model
module tb_wb_repne_cmps_sequencer;
  logic CLK = 1'b0;
  logic RST, WB_V, f_uop, s_uop, rep, hlt;
  logic [31:0] flags, cnt;
  logic ptr_en, pend, repl, term, done, halt_all, perr;
  logic [15:0] iter;
  logic ptr_en2, pend2, repl2, term2, done2, halt_all2, perr2;
  logic [2:0] iter2;
  int checks = 0, failures = 0;
  logic obs_ptr, exp_ptr;
  bit m_wait, m_halted, m_pend, m_err, m_repl, m_term, m_done;
  int m_iter;

  always #5 CLK = ~CLK;

  wb_repne_cmps_sequencer dut (
    .CLK(CLK), .RST(RST), .WB_V(WB_V), .CS_IS_CMPS_FIRST_UOP_ALL(f_uop),
    .CS_IS_CMPS_SECOND_UOP_ALL(s_uop), .WB_d2_repne_wb(rep), .CS_IS_HALT_WB(hlt),
    .current_flags(flags), .WB_RESULT_C(cnt), .cmps_ptr_en(ptr_en), .repne_pending(pend),
    .repne_replay(repl), .repne_terminate(term), .cmps_done(done), .wb_halt_all(halt_all),
    .protocol_error(perr), .iter_count(iter));

  wb_repne_cmps_sequencer #(.CNT_W(32), .ITER_W(3)) dut_small (
    .CLK(CLK), .RST(RST), .WB_V(WB_V), .CS_IS_CMPS_FIRST_UOP_ALL(f_uop),
    .CS_IS_CMPS_SECOND_UOP_ALL(s_uop), .WB_d2_repne_wb(rep), .CS_IS_HALT_WB(hlt),
    .current_flags(flags), .WB_RESULT_C(cnt), .cmps_ptr_en(ptr_en2), .repne_pending(pend2),
    .repne_replay(repl2), .repne_terminate(term2), .cmps_done(done2), .wb_halt_all(halt_all2),
    .protocol_error(perr2), .iter_count(iter2));

  // Model tracks only "awaiting second uop" and "halted"; the replay cycle is indistinguishable from idle.
  task automatic cyc(input logic rst, v, fi, se, rp, hl, input logic [31:0] fl, cc);
    RST = rst; WB_V = v; f_uop = fi; s_uop = se; rep = rp; hlt = hl; flags = fl; cnt = cc;
    #1 obs_ptr = ptr_en;
    exp_ptr = v && fi && !hl && !m_halted;
    @(posedge CLK); #1;
    m_repl = 0; m_term = 0; m_done = 0;
    if (rst) begin
      {m_wait, m_halted, m_pend, m_err} = '0;
      m_iter = 0;
    end else if (v && !m_halted) begin
      if (hl) m_halted = 1;
      else if (fi) begin
        if (m_wait) m_err = 1;
        m_wait = 1; m_pend = 1;
      end else if (se) begin
        if (!m_wait) m_err = 1;
        else begin
          m_wait = 0;
          if (!rp) begin m_done = 1; m_pend = 0; end
          else if (fl[6] || cc == 0) begin m_term = 1; m_pend = 0; m_iter = 0; end
          else begin m_repl = 1; m_iter++; end
        end
      end
    end
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 1, 1, 0, 0);
    checks++;
    if ({pend, repl, term, done, halt_all, perr} !== 6'b0 || iter !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got=%b iter=%0d exp=000000 iter=0", {pend, repl, term, done, halt_all, perr}, iter);
    end
  endtask

  task automatic test_plain_cmps();
    cyc(0, 1, 1, 0, 0, 0, 0, 32'd7);
    checks++;
    if (obs_ptr !== 1'b1) begin failures++; $display("FAIL plain_ptr_en got=%b exp=1", obs_ptr); end
    checks++;
    if (pend !== 1'b1) begin failures++; $display("FAIL plain_pending got=%b exp=1", pend); end
    cyc(0, 1, 0, 1, 0, 0, 0, 32'd7);
    checks++;
    if ({done, pend, perr} !== 3'b100) begin failures++; $display("FAIL plain_done got=%b exp=100", {done, pend, perr}); end
    idle_cyc();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL plain_done_pulse got=%b exp=0", done); end
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (perr !== 1'b0) begin failures++; $display("FAIL plain_back_to_idle got=%b exp=0", perr); end
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_repne_count();
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0, 32'd3);
    checks++;
    if ({repl, term, pend} !== 3'b101 || iter !== 16'd1) begin
      failures++; $display("FAIL repne_c3 got=%b iter=%0d exp=101 iter=1", {repl, term, pend}, iter);
    end
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0, 32'd2);
    checks++;
    if (repl !== 1'b1 || iter !== 16'd2) begin failures++; $display("FAIL repne_c2 got=%b iter=%0d exp=1 iter=2", repl, iter); end
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0, 32'd0);
    checks++;
    if ({repl, term, pend, perr} !== 4'b0100 || iter !== 16'd0) begin
      failures++; $display("FAIL repne_c0 got=%b iter=%0d exp=0100 iter=0", {repl, term, pend, perr}, iter);
    end
  endtask

  task automatic test_repne_zf();
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 32'h40, 32'd5);
    checks++;
    if ({repl, term} !== 2'b01) begin failures++; $display("FAIL repne_zf got=%b exp=01", {repl, term}); end
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 32'hFFFF_FFBF, 32'h8000_0000);
    checks++;
    if ({repl, term} !== 2'b10) begin failures++; $display("FAIL repne_highbit got=%b exp=10", {repl, term}); end
    idle_cyc();
  endtask

  task automatic test_halt();
    do_reset();
    cyc(0, 1, 1, 0, 0, 1, 0, 0);
    checks++;
    if (obs_ptr !== 1'b0) begin failures++; $display("FAIL halt_ptr_en got=%b exp=0", obs_ptr); end
    checks++;
    if (halt_all !== 1'b1) begin failures++; $display("FAIL halt_set got=%b exp=1", halt_all); end
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs_ptr !== 1'b0) begin failures++; $display("FAIL halted_ptr_en got=%b exp=0", obs_ptr); end
    cyc(0, 1, 0, 1, 1, 0, 0, 32'd4);
    checks++;
    if ({repl, term, done, perr, halt_all} !== 5'b00001) begin
      failures++; $display("FAIL halted_quiet got=%b exp=00001", {repl, term, done, perr, halt_all});
    end
    do_reset();
    checks++;
    if (halt_all !== 1'b0) begin failures++; $display("FAIL halt_clear got=%b exp=0", halt_all); end
  endtask

  task automatic test_protocol();
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({perr, done} !== 2'b10) begin failures++; $display("FAIL proto_second_idle got=%b exp=10", {perr, done}); end
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if ({obs_ptr, pend, perr} !== 3'b001) begin failures++; $display("FAIL proto_wbv0 got=%b exp=001", {obs_ptr, pend, perr}); end
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    checks++;
    if ({obs_ptr, pend, perr} !== 3'b111) begin failures++; $display("FAIL proto_double_first got=%b exp=111", {obs_ptr, pend, perr}); end
    do_reset();
  endtask

  task automatic test_reset_mid_pair();
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 0, 0, 32'd9);
    checks++;
    if ({pend, repl} !== 2'b00) begin failures++; $display("FAIL rst_mid_pending got=%b exp=00", {pend, repl}); end
    cyc(0, 1, 0, 1, 1, 0, 0, 32'd9);
    checks++;
    if ({perr, repl} !== 2'b10) begin failures++; $display("FAIL rst_mid_idle got=%b exp=10", {perr, repl}); end
    do_reset();
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 1, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 1, 0, 0, 32'd3);
    end
    checks++;
    if (iter2 !== 3'd7 || repl2 !== 1'b1 || iter !== 16'd10) begin
      failures++; $display("FAIL saturate got=%0d/%b/%0d exp=7/1/10", iter2, repl2, iter);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [15:0] e_iter;
    logic [2:0] e_iter2;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
          ($urandom_range(0, 3) == 0) ? 32'h40 : ($urandom & ~32'h40),
          ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      e_iter = (m_iter > 65535) ? 16'hFFFF : 16'(m_iter);
      e_iter2 = (m_iter > 7) ? 3'd7 : 3'(m_iter);
      checks++;
      if ({obs_ptr, pend, repl, term, done, halt_all, perr} !== {exp_ptr, m_pend, m_repl, m_term, m_done, m_halted, m_err}
          || iter !== e_iter || iter2 !== e_iter2) begin
        failures++;
        $display("FAIL random_%0d got=%b iter=%0d/%0d exp=%b iter=%0d/%0d", i,
                 {obs_ptr, pend, repl, term, done, halt_all, perr}, iter, iter2,
                 {exp_ptr, m_pend, m_repl, m_term, m_done, m_halted, m_err}, e_iter, e_iter2);
      end
    end
  endtask

  initial begin
    {RST, WB_V, f_uop, s_uop, rep, hlt} = 6'b100000;
    flags = 0; cnt = 0;
    @(posedge CLK); #1;
    test_reset();
    test_plain_cmps();
    test_repne_count();
    test_repne_zf();
    test_halt();
    test_protocol();
    test_reset_mid_pair();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
